music_speech_bus_ctrl: RTL and testbench
========================================

Name: music_speech_bus_ctrl

Overview:
- Cycle scheduler and interrupt front-end for the Music/Speech SOC 6809 core.
- Divides CLKIN into the CPU cycle-enable strobe.
- Shares the CPU bus slot with a host (CoCo-side) requester by asserting CPU hold for whole CPU cycles.
- Latches INT1_N/INT3_N falling edges into IRQ/FIRQ requests.

Parameters:
- DIV, 32: CLKIN cycles per CPU cycle (for example 57.27 MHz / 32 ≈ 1.79 MHz); legal range 4..256.
- MAX_HOLD, 4: maximum CPU-cycle boundaries per host tenure before forced release; legal range 1..15.

Ports:
- CLKIN  in  1  system clock; all logic is clocked on the rising edge.
- RESET  in  1  asynchronous reset, active-high.
- HOST_REQ  in  1  host bus request; level signal, held until done.
- HOST_DONE  in  1  one-cycle pulse ending the host tenure.
- HOST_GNT  out  1  host owns the shared bus.
- CPU_ENA  out  1  one-CLKIN-cycle CPU advance strobe.
- CPU_HOLD  out  1  stall request to the CPU.
- PHASE  out  clog2(DIV)  current phase counter value.
- INT1_N  in  1  asynchronous interrupt source, active-low.
- INT3_N  in  1  asynchronous interrupt source, active-low.
- IRQ_ACK  in  1  one-cycle pulse that clears pending IRQ.
- FIRQ_ACK  in  1  one-cycle pulse that clears pending FIRQ.
- CPU_IRQ_N  out  1  IRQ to the CPU, active-low.
- CPU_FIRQ_N  out  1  FIRQ to the CPU, active-low.

Behaviour:
- Reset (asynchronous, takes effect immediately):
  - PHASE=0, state=CPU_RUN, hold counter=0.
  - CPU_ENA=0, CPU_HOLD=0, HOST_GNT=0.
  - IRQ/FIRQ pending=0, so CPU_IRQ_N=1 and CPU_FIRQ_N=1.
  - Synchroniser flops preset to 1, so reset release produces no false edge.
- Phase counter:
  - Free-runs 0..DIV-1 and wraps to 0 in every state.
  - A "boundary" is any cycle with PHASE==DIV-1.
- CPU_ENA:
  - High for exactly the boundary cycle, when state is CPU_RUN or RECOVER.
  - Never high in HOST_OWN.
  - Decoded from registered state and phase only; no input feeds it combinationally.
- State machine, registered:
  - CPU_RUN: HOST_GNT=0, CPU_HOLD=0.
    - At a boundary with HOST_REQ=1: CPU_ENA still fires that cycle (the CPU completes its cycle); next state HOST_OWN; hold counter cleared.
    - HOST_REQ outside a boundary waits for the next boundary.
  - HOST_OWN: HOST_GNT=1, CPU_HOLD=1.
    - Leave to RECOVER on HOST_DONE=1 or HOST_REQ=0.
    - Each boundary increments the hold counter; at the boundary where it reaches MAX_HOLD, go to RECOVER (forced release).
    - HOST_DONE on that same boundary also gives RECOVER, with the same single transition.
    - HOST_GNT falls the cycle after the exit condition.
  - RECOVER: HOST_GNT=0, CPU_HOLD=0.
    - HOST_REQ is ignored.
    - At the next boundary CPU_ENA fires; next state CPU_RUN.
    - Guarantees at least one CPU cycle between host tenures, so the CPU cannot be starved.
- Interrupts:
  - Each input passes through a 2-flop synchroniser, then a previous-value flop for falling-edge detect.
  - An edge sets its pending flop; ACK clears it.
  - Set and ACK in the same cycle: set wins.
  - Edges while pending are absorbed, with no count.
  - CPU_IRQ_N = ~irq_pending and CPU_FIRQ_N = ~firq_pending, both registered.
  - Input fall to output fall: 3 CLKIN cycles.
  - ACK to output rise: 1 cycle.
- Reset during HOST_OWN: HOST_GNT and CPU_HOLD drop asynchronously; the host must re-request.
- Cycle numbering in the test plan counts from 0 at the first rising edge after RESET falls. DIV=32, MAX_HOLD=4.

Test Plan:
1. Idle after reset, HOST_REQ=0 -> CPU_ENA high only in cycles 31, 63, 95, ...; PHASE wraps 31->0; HOLD=0, GNT=0 throughout.
2. HOST_REQ rises at cycle 40, HOST_DONE pulses at cycle 80:
   - CPU_ENA fires at 63.
   - GNT=HOLD=1 for cycles 64..80.
   - GNT falls at 81.
   - No CPU_ENA in cycles 64..80; CPU_ENA fires at 95.
3. HOST_REQ held continuously from cycle 40 with no HOST_DONE:
   - GNT rises at 64.
   - No CPU_ENA at boundaries 95, 127, 159, 191.
   - GNT falls at 192 (timeout).
   - CPU_ENA fires at 223 (RECOVER ignores REQ).
   - GNT rises again at 256.
4. INT1_N low for one cycle at cycle 10 -> CPU_IRQ_N low from cycle 13; IRQ_ACK at cycle 20 -> CPU_IRQ_N high at 21; a second INT1_N pulse at cycle 15 causes no extra assertion.
5. INT3_N falls so that its edge is detected in the same cycle FIRQ_ACK pulses -> CPU_FIRQ_N stays low; a later FIRQ_ACK raises it next cycle.
6. RESET asserted mid-cycle at cycle 70, during HOST_OWN with IRQ pending -> GNT=0, HOLD=0, CPU_IRQ_N=1 before the next edge; after release the timing of scenario 1 restarts from cycle 0.

Source files
------------

// File: rtl/music_speech_bus_ctrl.sv
// Cycle scheduler and interrupt front-end for the Music/Speech 6809 core:
// CPU cycle-enable divider, host bus-slot arbitration and IRQ/FIRQ edge latching.
module music_speech_bus_ctrl #(
    parameter int DIV      = 32,
    parameter int MAX_HOLD = 4
) (
    input  logic                    CLKIN,
    input  logic                    RESET,
    input  logic                    HOST_REQ,
    input  logic                    HOST_DONE,
    output logic                    HOST_GNT,
    output logic                    CPU_ENA,
    output logic                    CPU_HOLD,
    output logic [$clog2(DIV)-1:0]  PHASE,
    input  logic                    INT1_N,
    input  logic                    INT3_N,
    input  logic                    IRQ_ACK,
    input  logic                    FIRQ_ACK,
    output logic                    CPU_IRQ_N,
    output logic                    CPU_FIRQ_N
);

    localparam int PW = $clog2(DIV);
    localparam logic [PW-1:0] LAST_PHASE = PW'(DIV - 1);
    localparam logic [3:0]    HOLD_LIMIT = 4'(MAX_HOLD);

    typedef enum logic [1:0] {
        CPU_RUN  = 2'd0,
        HOST_OWN = 2'd1,
        RECOVER  = 2'd2
    } state_t;

    state_t          state, state_next;
    logic [PW-1:0]   phase;
    logic [3:0]      hold_cnt, hold_next;
    logic            boundary;
    logic [3:0]      hold_inc;

    logic [1:0]      int_sync_p0;
    logic [1:0]      int_sync_p1;
    logic [1:0]      int_prev_p2;
    logic [1:0]      int_fall;
    logic            irq_pending;
    logic            firq_pending;

    assign boundary = (phase == LAST_PHASE);
    assign hold_inc = hold_cnt + 4'd1;

    always_ff @(posedge CLKIN or posedge RESET) begin
        if (RESET) begin
            phase <= '0;
        end else if (boundary) begin
            phase <= '0;
        end else begin
            phase <= phase + PW'(1);
        end
    end

    always_ff @(posedge CLKIN or posedge RESET) begin
        if (RESET) begin
            state    <= CPU_RUN;
            hold_cnt <= 4'd0;
        end else begin
            state    <= state_next;
            hold_cnt <= hold_next;
        end
    end

    // Outputs depend only on registered state and phase, never on inputs.
    always_comb begin
        state_next = state;
        hold_next  = hold_cnt;
        HOST_GNT   = 1'b0;
        CPU_HOLD   = 1'b0;
        CPU_ENA    = 1'b0;
        case (state)
            CPU_RUN: begin
                CPU_ENA = boundary;
                if (boundary && HOST_REQ) begin
                    state_next = HOST_OWN;
                    hold_next  = 4'd0;
                end
            end
            HOST_OWN: begin
                HOST_GNT = 1'b1;
                CPU_HOLD = 1'b1;
                if (boundary) begin
                    hold_next = hold_inc;
                end
                if (HOST_DONE || !HOST_REQ || (boundary && (hold_inc == HOLD_LIMIT))) begin
                    state_next = RECOVER;
                end
            end
            RECOVER: begin
                // One guaranteed CPU cycle between tenures; requests wait it out.
                CPU_ENA = boundary;
                if (boundary) begin
                    state_next = CPU_RUN;
                end
            end
            default: begin
                state_next = CPU_RUN;
            end
        endcase
    end

    // Synchroniser and previous-value flops preset high so reset release is edge-free.
    always_ff @(posedge CLKIN or posedge RESET) begin
        if (RESET) begin
            int_sync_p0 <= 2'b11;
            int_sync_p1 <= 2'b11;
            int_prev_p2 <= 2'b11;
        end else begin
            int_sync_p0 <= {INT3_N, INT1_N};
            int_sync_p1 <= int_sync_p0;
            int_prev_p2 <= int_sync_p1;
        end
    end

    assign int_fall = int_prev_p2 & ~int_sync_p1;

    // A new edge beats a simultaneous acknowledge so no request is lost.
    always_ff @(posedge CLKIN or posedge RESET) begin
        if (RESET) begin
            irq_pending  <= 1'b0;
            firq_pending <= 1'b0;
        end else begin
            if (int_fall[0]) begin
                irq_pending <= 1'b1;
            end else if (IRQ_ACK) begin
                irq_pending <= 1'b0;
            end
            if (int_fall[1]) begin
                firq_pending <= 1'b1;
            end else if (FIRQ_ACK) begin
                firq_pending <= 1'b0;
            end
        end
    end

    assign PHASE      = phase;
    assign CPU_IRQ_N  = ~irq_pending;
    assign CPU_FIRQ_N = ~firq_pending;

endmodule

// File: tb/tb_music_speech_bus_ctrl.sv
// Directed bench for music_speech_bus_ctrl with DIV=32, MAX_HOLD=4.
module tb_music_speech_bus_ctrl;

    logic       CLKIN = 1'b0;
    logic       RESET = 1'b1;
    logic       HOST_REQ = 1'b0;
    logic       HOST_DONE = 1'b0;
    logic       INT1_N = 1'b1;
    logic       INT3_N = 1'b1;
    logic       IRQ_ACK = 1'b0;
    logic       FIRQ_ACK = 1'b0;
    logic       HOST_GNT;
    logic       CPU_ENA;
    logic       CPU_HOLD;
    logic [4:0] PHASE;
    logic       CPU_IRQ_N;
    logic       CPU_FIRQ_N;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    music_speech_bus_ctrl #(.DIV(32), .MAX_HOLD(4)) dut (
        .CLKIN      (CLKIN),
        .RESET      (RESET),
        .HOST_REQ   (HOST_REQ),
        .HOST_DONE  (HOST_DONE),
        .HOST_GNT   (HOST_GNT),
        .CPU_ENA    (CPU_ENA),
        .CPU_HOLD   (CPU_HOLD),
        .PHASE      (PHASE),
        .INT1_N     (INT1_N),
        .INT3_N     (INT3_N),
        .IRQ_ACK    (IRQ_ACK),
        .FIRQ_ACK   (FIRQ_ACK),
        .CPU_IRQ_N  (CPU_IRQ_N),
        .CPU_FIRQ_N (CPU_FIRQ_N)
    );

    always #5 CLKIN = ~CLKIN;

    task automatic chk1(input string tag, input logic obs, input logic exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s cycle=%0d observed=%b expected=%b", tag, cyc, obs, exp);
        end
    endtask

    task automatic chkp(input string tag, input logic [4:0] obs, input logic [4:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s cycle=%0d observed=%0d expected=%0d", tag, cyc, obs, exp);
        end
    endtask

    // Advance to the next cycle; outputs are then sampled 1ns after the edge.
    task automatic tick();
        @(posedge CLKIN);
        #1;
        cyc++;
    endtask

    task automatic do_reset();
        RESET = 1'b1;
        repeat (3) @(posedge CLKIN);
        #1;
        chk1("rst_gnt", HOST_GNT, 1'b0);
        chk1("rst_hold", CPU_HOLD, 1'b0);
        chk1("rst_ena", CPU_ENA, 1'b0);
        chkp("rst_phase", PHASE, 5'd0);
        chk1("rst_irq_n", CPU_IRQ_N, 1'b1);
        chk1("rst_firq_n", CPU_FIRQ_N, 1'b1);
        @(negedge CLKIN);
        RESET = 1'b0;
        cyc = 0;
    endtask

    initial begin
        // Scenario 1 + 4: idle bus, IRQ latch/ack with absorbed second edge
        do_reset();
        while (cyc <= 100) begin
            chkp("s1_phase", PHASE, 5'(cyc % 32));
            chk1("s1_ena", CPU_ENA, (cyc % 32) == 31);
            chk1("s1_gnt", HOST_GNT, 1'b0);
            chk1("s1_hold", CPU_HOLD, 1'b0);
            chk1("s4_irq_n", CPU_IRQ_N, !(cyc >= 13 && cyc <= 20));
            chk1("s4_firq_n", CPU_FIRQ_N, 1'b1);
            INT1_N  = !(cyc == 10 || cyc == 15);
            IRQ_ACK = (cyc == 20);
            tick();
        end
        INT1_N  = 1'b1;
        IRQ_ACK = 1'b0;

        // Scenario 2: host tenure ended by HOST_DONE
        do_reset();
        while (cyc <= 130) begin
            chk1("s2_gnt", HOST_GNT, cyc >= 64 && cyc <= 80);
            chk1("s2_hold", CPU_HOLD, cyc >= 64 && cyc <= 80);
            chk1("s2_ena", CPU_ENA, cyc == 31 || cyc == 63 || cyc == 95 || cyc == 127);
            HOST_REQ  = (cyc >= 40 && cyc <= 80);
            HOST_DONE = (cyc == 80);
            tick();
        end
        HOST_REQ  = 1'b0;
        HOST_DONE = 1'b0;

        // Scenario 3 + 5: forced release after MAX_HOLD, FIRQ set beats ack
        do_reset();
        while (cyc <= 260) begin
            chk1("s3_gnt", HOST_GNT, (cyc >= 64 && cyc <= 191) || cyc >= 256);
            chk1("s3_hold", CPU_HOLD, (cyc >= 64 && cyc <= 191) || cyc >= 256);
            chk1("s3_ena", CPU_ENA, cyc == 31 || cyc == 63 || cyc == 223 || cyc == 255);
            chk1("s5_firq_n", CPU_FIRQ_N, !(cyc >= 33 && cyc <= 40));
            HOST_REQ = (cyc >= 40);
            INT3_N   = !(cyc >= 30 && cyc < 50);
            FIRQ_ACK = (cyc == 32 || cyc == 40);
            tick();
        end
        HOST_REQ = 1'b0;
        INT3_N   = 1'b1;
        FIRQ_ACK = 1'b0;

        // Scenario 6: asynchronous reset during HOST_OWN with IRQ pending
        do_reset();
        while (cyc < 70) begin
            HOST_REQ = (cyc >= 40);
            INT1_N   = (cyc != 10);
            tick();
        end
        chk1("s6_pre_gnt", HOST_GNT, 1'b1);
        chk1("s6_pre_hold", CPU_HOLD, 1'b1);
        chk1("s6_pre_irq_n", CPU_IRQ_N, 1'b0);
        #2;
        RESET = 1'b1;
        #1;
        chk1("s6_async_gnt", HOST_GNT, 1'b0);
        chk1("s6_async_hold", CPU_HOLD, 1'b0);
        chk1("s6_async_irq_n", CPU_IRQ_N, 1'b1);
        chkp("s6_async_phase", PHASE, 5'd0);
        HOST_REQ = 1'b0;
        INT1_N   = 1'b1;
        do_reset();
        while (cyc <= 70) begin
            chkp("s6_phase", PHASE, 5'(cyc % 32));
            chk1("s6_ena", CPU_ENA, (cyc % 32) == 31);
            chk1("s6_gnt", HOST_GNT, 1'b0);
            chk1("s6_irq_n", CPU_IRQ_N, 1'b1);
            tick();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
